// File: rtl/serv_bus_arbiter_pkg.sv
// Shared definitions for the SERV instruction/data bus arbiter.
//   - Wishbone field widths used by the arbiter ports
//   - watchdog counter width
//   - FSM state encoding (idle, ibus owns port, dbus owns port)
//   - byte select driven for instruction fetches
//   - tie-break helper used when leaving idle
package serv_bus_arbiter_pkg;

  localparam int unsigned WB_AW  = 32;
  localparam int unsigned WB_DW  = 32;
  localparam int unsigned WB_SW  = 4;
  localparam int unsigned WDOG_W = 16;

  localparam logic [WB_SW-1:0] IBUS_SEL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IBUS = 2'd1,
    ST_DBUS = 2'd2
  } arb_state_e;

  // Returns 1 when the dbus should be granted. Only meaningful when at least
  // one request is present. On a tie, fixed priority favours the dbus;
  // round-robin hands the port to whichever master did not own it last.
  function automatic logic pick_dbus(input logic ireq,
                                     input logic dreq,
                                     input logic rr_en,
                                     input logic last_dbus);
    if (ireq && dreq) return rr_en ? ~last_dbus : 1'b1;
    return dreq;
  endfunction

endpackage

// File: rtl/serv_bus_arbiter_wdog.sv
// Transaction watchdog for the bus arbiter.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_clr    : clear the counter (held while no transaction is granted)
//   i_en     : count one granted cycle without acknowledge
//   o_expire : counter has reached TIMEOUT-1 (never asserted for TIMEOUT=0)
// The counter saturates at all-ones instead of wrapping.
module serv_bus_wdog
  import serv_bus_arbiter_pkg::*;
#(
  parameter logic [WDOG_W-1:0] TIMEOUT = 16'd0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    o_expire = (TIMEOUT != '0) && (cnt == (TIMEOUT - 16'd1));
  end

endmodule

// File: rtl/serv_bus_arbiter.sv
// Two-master arbiter sharing one classic Wishbone port between the SERV
// instruction bus and data bus.
//   i_clk, i_rst_n          : clock (rising edge), async active-low reset
//   i_ibus_*/o_ibus_*       : instruction fetch master (read only)
//   i_dbus_*/o_dbus_*       : data master (read/write, byte selects)
//   o_wb_*/i_wb_*           : shared slave port; adr/dat/sel/we/cyc registered
//   o_timeout               : one-cycle pulse when the watchdog ends a transfer
//   o_gnt_dbus              : registered, high while the dbus owns the port
// Grant and request fields are captured on leaving idle and held for the
// whole transfer. Slave ack/rdt are forwarded combinationally to the owner.
module serv_bus_arbiter
  import serv_bus_arbiter_pkg::*;
#(
  parameter logic              RR_EN   = 1'b0,
  parameter logic [WDOG_W-1:0] TIMEOUT = 16'd0,
  parameter logic [WB_DW-1:0]  ERR_RDT = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WB_AW-1:0] i_ibus_adr,
  input  logic             i_ibus_cyc,
  output logic [WB_DW-1:0] o_ibus_rdt,
  output logic             o_ibus_ack,
  input  logic [WB_AW-1:0] i_dbus_adr,
  input  logic [WB_DW-1:0] i_dbus_dat,
  input  logic [WB_SW-1:0] i_dbus_sel,
  input  logic             i_dbus_we,
  input  logic             i_dbus_cyc,
  output logic [WB_DW-1:0] o_dbus_rdt,
  output logic             o_dbus_ack,
  output logic [WB_AW-1:0] o_wb_adr,
  output logic [WB_DW-1:0] o_wb_dat,
  output logic [WB_SW-1:0] o_wb_sel,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  input  logic [WB_DW-1:0] i_wb_rdt,
  input  logic             i_wb_ack,
  output logic             o_timeout,
  output logic             o_gnt_dbus
);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic             last_dbus;
  logic             granted;
  logic             owner_cyc;
  logic             wd_expire;
  logic             tmo_fire;
  logic [WB_DW-1:0] fwd_rdt;

  assign granted   = (state != ST_IDLE);
  assign owner_cyc = (state == ST_DBUS) ? i_dbus_cyc : i_ibus_cyc;
  // A real acknowledge in the expiry cycle wins over the watchdog.
  assign tmo_fire  = granted && wd_expire && !i_wb_ack;
  assign fwd_rdt   = tmo_fire ? ERR_RDT : i_wb_rdt;

  serv_bus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (!granted),
    .i_en     (granted && !i_wb_ack),
    .o_expire (wd_expire)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Granted states always fall back to idle, which
  // enforces one idle cycle between any two transfers.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_ibus_cyc || i_dbus_cyc) begin
          state_nxt = pick_dbus(i_ibus_cyc, i_dbus_cyc, RR_EN, last_dbus)
                      ? ST_DBUS : ST_IBUS;
        end
      end
      ST_IBUS, ST_DBUS: begin
        if (i_wb_ack || tmo_fire || !owner_cyc) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered port fields. cyc/gnt follow the next state so they line up
  // with the state register; the request fields are latched only on grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_cyc   <= 1'b0;
      o_gnt_dbus <= 1'b0;
      o_wb_adr   <= '0;
      o_wb_dat   <= '0;
      o_wb_sel   <= '0;
      o_wb_we    <= 1'b0;
      last_dbus  <= 1'b0;
    end else begin
      o_wb_cyc   <= (state_nxt != ST_IDLE);
      o_gnt_dbus <= (state_nxt == ST_DBUS);
      if (state == ST_IDLE) begin
        if (state_nxt == ST_DBUS) begin
          o_wb_adr  <= i_dbus_adr;
          o_wb_dat  <= i_dbus_dat;
          o_wb_sel  <= i_dbus_sel;
          o_wb_we   <= i_dbus_we;
          last_dbus <= 1'b1;
        end else if (state_nxt == ST_IBUS) begin
          o_wb_adr  <= i_ibus_adr;
          o_wb_dat  <= '0;
          o_wb_sel  <= IBUS_SEL;
          o_wb_we   <= 1'b0;
          last_dbus <= 1'b0;
        end
      end
    end
  end

  // Master-side outputs: only the current owner sees ack/rdt.
  always_comb begin
    o_ibus_ack = 1'b0;
    o_ibus_rdt = '0;
    o_dbus_ack = 1'b0;
    o_dbus_rdt = '0;
    o_timeout  = tmo_fire;
    case (state)
      ST_IBUS: begin
        o_ibus_ack = i_wb_ack || tmo_fire;
        o_ibus_rdt = fwd_rdt;
      end
      ST_DBUS: begin
        o_dbus_ack = i_wb_ack || tmo_fire;
        o_dbus_rdt = fwd_rdt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Bench for serv_bus_arbiter: dut0 = fixed priority with TIMEOUT=4,
// dut1 = round-robin with watchdog disabled.
module tb_serv_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] ibus_adr[2], dbus_adr[2], dbus_dat[2], wb_rdt[2];
  logic [3:0]  dbus_sel[2];
  logic        ibus_cyc[2], dbus_we[2], dbus_cyc[2], wb_ack[2];
  logic [31:0] ibus_rdt[2], dbus_rdt[2], wb_adr[2], wb_dat[2];
  logic [3:0]  wb_sel[2];
  logic        ibus_ack[2], dbus_ack[2], wb_we[2], wb_cyc[2], tmo[2], gnt[2];

  serv_bus_arbiter #(.RR_EN(1'b0), .TIMEOUT(16'd4), .ERR_RDT(32'hDEAD_BEEF)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr[0]), .i_ibus_cyc(ibus_cyc[0]),
    .o_ibus_rdt(ibus_rdt[0]), .o_ibus_ack(ibus_ack[0]),
    .i_dbus_adr(dbus_adr[0]), .i_dbus_dat(dbus_dat[0]), .i_dbus_sel(dbus_sel[0]),
    .i_dbus_we(dbus_we[0]), .i_dbus_cyc(dbus_cyc[0]),
    .o_dbus_rdt(dbus_rdt[0]), .o_dbus_ack(dbus_ack[0]),
    .o_wb_adr(wb_adr[0]), .o_wb_dat(wb_dat[0]), .o_wb_sel(wb_sel[0]),
    .o_wb_we(wb_we[0]), .o_wb_cyc(wb_cyc[0]),
    .i_wb_rdt(wb_rdt[0]), .i_wb_ack(wb_ack[0]),
    .o_timeout(tmo[0]), .o_gnt_dbus(gnt[0]));

  serv_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT(16'd0), .ERR_RDT(32'h0BAD_F00D)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr[1]), .i_ibus_cyc(ibus_cyc[1]),
    .o_ibus_rdt(ibus_rdt[1]), .o_ibus_ack(ibus_ack[1]),
    .i_dbus_adr(dbus_adr[1]), .i_dbus_dat(dbus_dat[1]), .i_dbus_sel(dbus_sel[1]),
    .i_dbus_we(dbus_we[1]), .i_dbus_cyc(dbus_cyc[1]),
    .o_dbus_rdt(dbus_rdt[1]), .o_dbus_ack(dbus_ack[1]),
    .o_wb_adr(wb_adr[1]), .o_wb_dat(wb_dat[1]), .o_wb_sel(wb_sel[1]),
    .o_wb_we(wb_we[1]), .o_wb_cyc(wb_cyc[1]),
    .i_wb_rdt(wb_rdt[1]), .i_wb_ack(wb_ack[1]),
    .o_timeout(tmo[1]), .o_gnt_dbus(gnt[1]));

  int total = 0;
  int bad   = 0;
  bit rnd_en = 1'b0;
  bit chk_on = 1'b0;
  bit e_iack[2], e_dack[2];

  // Reference model: owner 0=none, 1=ibus, 2=dbus; wait = granted cycles so far.
  int          m_own[2], m_wait[2], m_last[2];
  logic [31:0] m_adr[2], m_dat[2];
  logic [3:0]  m_sel[2];
  logic        m_we[2];

  function automatic int to_of(int d); return (d == 0) ? 4 : 0; endfunction
  function automatic bit rr_of(int d); return (d == 1); endfunction
  function automatic logic [31:0] err_of(int d);
    return (d == 0) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
  endfunction

  function automatic bit m_fire(int d);
    return (to_of(d) > 0) && (m_own[d] != 0) && !wb_ack[d] && (m_wait[d] == to_of(d) - 1);
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  task automatic m_reset(int d);
    m_own[d] = 0; m_wait[d] = 0; m_last[d] = 1;
    m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0; m_we[d] = 1'b0;
  endtask

  task automatic m_step(int d);
    bit f, oc;
    int w;
    f = m_fire(d);
    if (m_own[d] == 0) begin
      w = 0;
      if (ibus_cyc[d] && dbus_cyc[d]) w = rr_of(d) ? ((m_last[d] == 2) ? 1 : 2) : 2;
      else if (dbus_cyc[d]) w = 2;
      else if (ibus_cyc[d]) w = 1;
      if (w != 0) begin
        m_own[d] = w; m_wait[d] = 0; m_last[d] = w;
        if (w == 1) begin
          m_adr[d] = ibus_adr[d]; m_dat[d] = '0; m_sel[d] = 4'hF; m_we[d] = 1'b0;
        end else begin
          m_adr[d] = dbus_adr[d]; m_dat[d] = dbus_dat[d]; m_sel[d] = dbus_sel[d]; m_we[d] = dbus_we[d];
        end
      end
    end else begin
      oc = (m_own[d] == 1) ? ibus_cyc[d] : dbus_cyc[d];
      if (wb_ack[d] || f || !oc) m_own[d] = 0;
      else if (m_wait[d] < 65535) m_wait[d]++;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) m_reset(d);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) m_reset(d);
        else m_step(d);
      end
    end
  end

  // Continuous comparison against the model, mid low phase.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_on) begin
        for (int d = 0; d < 2; d++) begin
          bit f, ia, da;
          logic [31:0] r;
          f  = m_fire(d);
          ia = (m_own[d] == 1) && (wb_ack[d] || f);
          da = (m_own[d] == 2) && (wb_ack[d] || f);
          r  = f ? err_of(d) : wb_rdt[d];
          e_iack[d] = ia;
          e_dack[d] = da;
          chk("m_cyc", d, wb_cyc[d], m_own[d] != 0);
          chk("m_gnt", d, gnt[d], m_own[d] == 2);
          chk("m_tmo", d, tmo[d], f);
          chk("m_iack", d, ibus_ack[d], ia);
          chk("m_dack", d, dbus_ack[d], da);
          chk("m_irdt", d, ibus_rdt[d], (m_own[d] == 1) ? r : 32'h0);
          chk("m_drdt", d, dbus_rdt[d], (m_own[d] == 2) ? r : 32'h0);
          if (m_own[d] != 0) begin
            chk("m_adr", d, wb_adr[d], m_adr[d]);
            chk("m_dat", d, wb_dat[d], m_dat[d]);
            chk("m_sel", d, wb_sel[d], m_sel[d]);
            chk("m_we", d, wb_we[d], m_we[d]);
          end
        end
      end
    end
  end

  // Random masters and slave, active only in the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_en) begin
        for (int d = 0; d < 2; d++) begin
          if (ibus_cyc[d]) begin
            if (e_iack[d] || $urandom_range(15) == 0) ibus_cyc[d] = 1'b0;
          end else if ($urandom_range(2) == 0) begin
            ibus_cyc[d] = 1'b1;
            ibus_adr[d] = $urandom & 32'hFFFF_FFFC;
          end
          if (dbus_cyc[d]) begin
            if (e_dack[d] || $urandom_range(15) == 0) dbus_cyc[d] = 1'b0;
          end else if ($urandom_range(2) == 0) begin
            dbus_cyc[d] = 1'b1;
            dbus_adr[d] = $urandom;
            dbus_dat[d] = $urandom;
            dbus_sel[d] = 4'($urandom_range(15));
            dbus_we[d]  = 1'($urandom_range(1));
          end
          wb_ack[d] = ($urandom_range(3) == 0);
          wb_rdt[d] = $urandom;
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      ibus_adr[d] = '0; ibus_cyc[d] = 1'b0;
      dbus_adr[d] = '0; dbus_dat[d] = '0; dbus_sel[d] = '0;
      dbus_we[d] = 1'b0; dbus_cyc[d] = 1'b0;
      wb_ack[d] = 1'b0; wb_rdt[d] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(string nm, int d);
    chk({nm, "_cyc"}, d, wb_cyc[d], 0);
    chk({nm, "_gnt"}, d, gnt[d], 0);
    chk({nm, "_adr"}, d, wb_adr[d], 0);
    chk({nm, "_dat"}, d, wb_dat[d], 0);
    chk({nm, "_sel"}, d, wb_sel[d], 0);
    chk({nm, "_we"}, d, wb_we[d], 0);
    chk({nm, "_tmo"}, d, tmo[d], 0);
    chk({nm, "_iack"}, d, ibus_ack[d], 0);
    chk({nm, "_dack"}, d, dbus_ack[d], 0);
  endtask

  typedef struct {
    bit icyc; bit dcyc; bit dwe;
    logic [31:0] iadr; logic [31:0] dadr; logic [31:0] ddat; logic [3:0] dsel;
    logic [31:0] rdt;
    bit e_cyc; bit e_gnt; bit e_we;
    logic [31:0] e_adr; logic [31:0] e_dat; logic [3:0] e_sel;
    bit e_iack; bit e_dack;
  } vec_t;

  vec_t tv[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{icyc:1, dcyc:0, dwe:0, iadr:32'h100, dadr:0, ddat:0, dsel:0, rdt:32'h1111_0000,
              e_cyc:1, e_gnt:0, e_we:0, e_adr:32'h100, e_dat:0, e_sel:4'hF, e_iack:1, e_dack:0};
    tv[1] = '{icyc:0, dcyc:1, dwe:1, iadr:0, dadr:32'h2000, ddat:32'hA5A5_A5A5, dsel:4'h3, rdt:32'h2222_0000,
              e_cyc:1, e_gnt:1, e_we:1, e_adr:32'h2000, e_dat:32'hA5A5_A5A5, e_sel:4'h3, e_iack:0, e_dack:1};
    tv[2] = '{icyc:1, dcyc:1, dwe:1, iadr:32'h8, dadr:32'h2000, ddat:32'hA5A5_A5A5, dsel:4'h3, rdt:32'h3333_0000,
              e_cyc:1, e_gnt:1, e_we:1, e_adr:32'h2000, e_dat:32'hA5A5_A5A5, e_sel:4'h3, e_iack:0, e_dack:1};
    tv[3] = '{icyc:0, dcyc:0, dwe:0, iadr:32'h44, dadr:32'h88, ddat:0, dsel:0, rdt:32'h4444_0000,
              e_cyc:0, e_gnt:0, e_we:0, e_adr:0, e_dat:0, e_sel:0, e_iack:0, e_dack:0};
    tv[4] = '{icyc:1, dcyc:1, dwe:0, iadr:32'hC, dadr:32'h3000, ddat:32'h1111_2222, dsel:4'hC, rdt:32'h5555_0000,
              e_cyc:1, e_gnt:1, e_we:0, e_adr:32'h3000, e_dat:32'h1111_2222, e_sel:4'hC, e_iack:0, e_dack:1};
    tv[5] = '{icyc:1, dcyc:0, dwe:0, iadr:32'hFFFF_FFFC, dadr:0, ddat:0, dsel:0, rdt:32'hFFFF_FFFF,
              e_cyc:1, e_gnt:0, e_we:0, e_adr:32'hFFFF_FFFC, e_dat:0, e_sel:4'hF, e_iack:1, e_dack:0};

    rst_n = 1'b0;
    clear_inputs();
    #2;
    for (int d = 0; d < 2; d++) chk_reset_vals("rst", d);
    chk_on = 1'b1;
    do_reset();

    // Single ibus fetch, slave acks two cycles after cyc is seen.
    @(negedge clk); ibus_cyc[0] = 1'b1; ibus_adr[0] = 32'h100;
    #1 chk("a_cyc_pre", 0, wb_cyc[0], 0);
    @(negedge clk); #1;
    chk("a_cyc", 0, wb_cyc[0], 1); chk("a_adr", 0, wb_adr[0], 32'h100);
    chk("a_sel", 0, wb_sel[0], 4'hF); chk("a_we", 0, wb_we[0], 0);
    chk("a_dat", 0, wb_dat[0], 0); chk("a_iack0", 0, ibus_ack[0], 0);
    @(negedge clk); #1;
    chk("a_cyc1", 0, wb_cyc[0], 1); chk("a_iack1", 0, ibus_ack[0], 0);
    @(negedge clk); wb_ack[0] = 1'b1; wb_rdt[0] = 32'hCAFE_0001; #1;
    chk("a_iack", 0, ibus_ack[0], 1); chk("a_irdt", 0, ibus_rdt[0], 32'hCAFE_0001);
    chk("a_dack", 0, dbus_ack[0], 0); chk("a_drdt", 0, dbus_rdt[0], 0);
    @(negedge clk); wb_ack[0] = 1'b0; ibus_cyc[0] = 1'b0; #1;
    chk("a_cyc_end", 0, wb_cyc[0], 0);

    // Simultaneous requests, fixed priority: dbus, idle cycle, then ibus.
    @(negedge clk);
    ibus_cyc[0] = 1'b1; ibus_adr[0] = 32'h8;
    dbus_cyc[0] = 1'b1; dbus_adr[0] = 32'h2000; dbus_dat[0] = 32'hA5A5_A5A5;
    dbus_sel[0] = 4'h3; dbus_we[0] = 1'b1;
    @(negedge clk); wb_ack[0] = 1'b1; #1;
    chk("b_gnt", 0, gnt[0], 1); chk("b_we", 0, wb_we[0], 1);
    chk("b_adr", 0, wb_adr[0], 32'h2000); chk("b_dat", 0, wb_dat[0], 32'hA5A5_A5A5);
    chk("b_sel", 0, wb_sel[0], 4'h3); chk("b_dack", 0, dbus_ack[0], 1);
    chk("b_iack", 0, ibus_ack[0], 0);
    @(negedge clk); wb_ack[0] = 1'b0; dbus_cyc[0] = 1'b0; #1;
    chk("b_idle", 0, wb_cyc[0], 0);
    @(negedge clk); wb_ack[0] = 1'b1; #1;
    chk("b_cyc2", 0, wb_cyc[0], 1); chk("b_gnt2", 0, gnt[0], 0);
    chk("b_adr2", 0, wb_adr[0], 32'h8); chk("b_iack2", 0, ibus_ack[0], 1);
    @(negedge clk); wb_ack[0] = 1'b0; ibus_cyc[0] = 1'b0; #1;
    chk("b_end", 0, wb_cyc[0], 0);

    // Table-driven grant and routing checks on the fixed-priority instance.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ibus_cyc[0] = tv[i].icyc; ibus_adr[0] = tv[i].iadr;
      dbus_cyc[0] = tv[i].dcyc; dbus_adr[0] = tv[i].dadr; dbus_dat[0] = tv[i].ddat;
      dbus_sel[0] = tv[i].dsel; dbus_we[0] = tv[i].dwe; wb_ack[0] = 1'b0;
      @(negedge clk); wb_ack[0] = 1'b1; wb_rdt[0] = tv[i].rdt; #1;
      chk("t_cyc", i, wb_cyc[0], tv[i].e_cyc);
      chk("t_gnt", i, gnt[0], tv[i].e_gnt);
      if (tv[i].e_cyc) begin
        chk("t_adr", i, wb_adr[0], tv[i].e_adr); chk("t_dat", i, wb_dat[0], tv[i].e_dat);
        chk("t_sel", i, wb_sel[0], tv[i].e_sel); chk("t_we", i, wb_we[0], tv[i].e_we);
      end
      chk("t_iack", i, ibus_ack[0], tv[i].e_iack);
      chk("t_dack", i, dbus_ack[0], tv[i].e_dack);
      chk("t_irdt", i, ibus_rdt[0], tv[i].e_iack ? tv[i].rdt : 32'h0);
      chk("t_drdt", i, dbus_rdt[0], tv[i].e_dack ? tv[i].rdt : 32'h0);
      @(negedge clk); clear_inputs(); #1;
      chk("t_end", i, wb_cyc[0], 0);
    end

    // Round-robin with immediate acks: dbus, ibus, dbus, ibus.
    do_reset();
    @(negedge clk);
    ibus_cyc[1] = 1'b1; ibus_adr[1] = 32'h40;
    dbus_cyc[1] = 1'b1; dbus_adr[1] = 32'h80; wb_ack[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      if (k % 2 == 1) begin
        chk("c_cyc", k, wb_cyc[1], 1);
        chk("c_gnt", k, gnt[1], (k % 4) == 1);
        chk("c_adr", k, wb_adr[1], ((k % 4) == 1) ? 32'h80 : 32'h40);
      end else begin
        chk("c_idle", k, wb_cyc[1], 0);
      end
    end
    @(negedge clk); clear_inputs();

    // Watchdog: slave never acks, expiry in the 4th granted cycle.
    do_reset();
    @(negedge clk); dbus_cyc[0] = 1'b1; dbus_adr[0] = 32'h44; dbus_sel[0] = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk("d_cyc", k, wb_cyc[0], 1);
      chk("d_tmo", k, tmo[0], k == 4);
      chk("d_dack", k, dbus_ack[0], k == 4);
      if (k == 4) chk("d_rdt", k, dbus_rdt[0], 32'hDEAD_BEEF);
    end
    @(negedge clk); dbus_cyc[0] = 1'b0; #1;
    chk("d_cyc_end", 0, wb_cyc[0], 0); chk("d_tmo_end", 0, tmo[0], 0);
    @(negedge clk); wb_ack[0] = 1'b1; wb_rdt[0] = 32'h5A5A_5A5A; #1;
    chk("d_stray_dack", 0, dbus_ack[0], 0); chk("d_stray_iack", 0, ibus_ack[0], 0);
    // Real ack in the expiry cycle takes precedence.
    @(negedge clk); wb_ack[0] = 1'b0; dbus_cyc[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin wb_ack[0] = 1'b1; wb_rdt[0] = 32'h7777_7777; end
      #1;
      chk("e_dack", k, dbus_ack[0], k == 4);
      chk("e_tmo", k, tmo[0], 0);
      if (k == 4) chk("e_rdt", k, dbus_rdt[0], 32'h7777_7777);
    end
    @(negedge clk); wb_ack[0] = 1'b0; dbus_cyc[0] = 1'b0; #1;
    chk("e_end", 0, wb_cyc[0], 0);

    // Abort: dbus drops cyc after one granted cycle; late ack ignored.
    do_reset();
    @(negedge clk); dbus_cyc[0] = 1'b1; dbus_adr[0] = 32'h500; dbus_we[0] = 1'b1;
    @(negedge clk); #1 chk("f_cyc", 0, wb_cyc[0], 1);
    @(negedge clk); dbus_cyc[0] = 1'b0; #1;
    chk("f_cyc_hold", 0, wb_cyc[0], 1); chk("f_dack0", 0, dbus_ack[0], 0);
    @(negedge clk); wb_ack[0] = 1'b1; #1;
    chk("f_cyc_end", 0, wb_cyc[0], 0); chk("f_late_dack", 0, dbus_ack[0], 0);
    @(negedge clk); wb_ack[0] = 1'b0;

    // Reset mid-transaction.
    do_reset();
    @(negedge clk);
    dbus_cyc[0] = 1'b1; dbus_adr[0] = 32'h600; dbus_dat[0] = 32'h1234_5678;
    dbus_sel[0] = 4'h5; dbus_we[0] = 1'b1;
    @(negedge clk); #1;
    chk("g_cyc", 0, wb_cyc[0], 1); chk("g_gnt", 0, gnt[0], 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("g_rst", 0);
    @(negedge clk); clear_inputs();
    @(negedge clk); rst_n = 1'b1;

    // Random phase against the reference model.
    do_reset();
    @(negedge clk); rnd_en = 1'b1;
    repeat (3000) @(negedge clk);
    rnd_en = 1'b0;
    clear_inputs();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
